ocx_dlx_xlx_if_gen: RTL and testbench
=====================================

// Module: ocx_dlx_xlx_if_gen
// PURPOSE
//  Parametrised DLx <-> Xilinx GT glue, single clock domain (opt_gckn). Debounces ocde into GT reset-all,
//  pulses GT rx datapath reset once all enabled lanes report run_lane, gates init_done/rx_valid per lane,
//  sequences dlx_reset for send-first/receive-first links. Adds over prior gen: lane count/mask,
//  programmable pulse width, rx-done watchdog with bounded retrain retries, fail/status reporting.
// PARAMETERS
//  LANES          8     number of lanes (1..16)
//  PULSE_CYCLES   8     cycles gtwiz_reset_rx_datapath_out held high (>=2)
//  DEBOUNCE_DEPTH 5     consecutive equal ocde samples required to change reset-all
//  TIMEOUT_CYCLES 4096  cycles allowed in PULSE_DONE for rx_done before a retry pulse
//  MAX_RETRAIN    3     retry pulses allowed before FAIL (1..15)
// PORTS
//  opt_gckn                    in  1      rx-domain clock, all flops on rising edge
//  reset_n                     in  1      asynchronous active-low reset
//  ocde                        in  1      async board reset request, low = reset
//  lane_enable                 in  LANES  quasi-static lane mask (1 = lane participates)
//  send_first                  in  1      1 = transmit pattern A as soon as tx ready
//  gtwiz_reset_tx_done_in / gtwiz_reset_rx_done_in / gtwiz_buffbypass_tx_done_in /
//  gtwiz_buffbypass_rx_done_in / gtwiz_userclk_rx_active_in   in 1 each   GT status
//  pb_io_o0_rx_run_lane        in  LANES  per-lane sync-pattern-found from DLx
//  rx_valid_in                 in  LANES  per-lane GT rx valid
//  gtwiz_reset_all_out         out 1      debounced GT reset-all, 1 = reset
//  gtwiz_reset_rx_datapath_out out 1      rx datapath reset pulse
//  dlx_reset                   out 1      DLx reset, 1 = held
//  io_pb_o0_rx_init_done       out LANES  per-lane rx init done to DLx
//  rx_valid_out                out LANES  gated rx valid
//  retrain_count               out 4      retry pulses issued since last sync, saturating
//  retrain_fail                out 1      1 = FAIL state
// BEHAVIOUR
//  Reset (reset_n=0): FSM=FIND_SYNC, counters 0, debounce shift reg all 0, gtwiz_reset_all_out=1,
//   dlx_reset=1, rx_datapath_out=0, init_done=0, retrain_count=0, retrain_fail=0, rec_first=0.
//  ocde: 2-flop synchroniser then DEBOUNCE_DEPTH shift reg; all-1 & out=1 -> out 0; all-0 & out=0 -> out 1;
//   else hold. Latency ocde edge -> output change = 2+DEBOUNCE_DEPTH+1 cycles.
//  rx_ok = gtwiz_reset_rx_done_in & gtwiz_buffbypass_rx_done_in; tx_lost = ~tx_done & ~buffbypass_tx_done.
//  sync_all = |lane_enable & &(pb_io_o0_rx_run_lane | ~lane_enable); lane_enable==0 never syncs.
//  FSM (registered state, Moore outputs):
//   FIND_SYNC : cnt<=0; sync_all -> HOLD_PULSE, retrain_count<=0.
//   HOLD_PULSE: rx_datapath_out=1; cnt++; cnt==PULSE_CYCLES-1 -> PULSE_DONE, cnt<=0 (exactly PULSE_CYCLES high).
//   PULSE_DONE: init_done = lane_enable & {LANES{rx_ok & userclk_rx_active}}. Priority:
//    1 tx_lost -> FIND_SYNC (link retrain; no count);
//    2 rx_ok -> stay, cnt held 0;
//    3 cnt==TIMEOUT_CYCLES-1: retrain_count==MAX_RETRAIN -> FAIL else retrain_count++, -> HOLD_PULSE;
//    4 else cnt++.
//   FAIL      : retrain_fail=1, init_done=0; leaves to FIND_SYNC only when gtwiz_reset_all_out=1.
//   gtwiz_reset_all_out=1 in any state -> FIND_SYNC next cycle (overrides all transitions).
//   Illegal encodings -> FIND_SYNC.
//  dlx_reset: send_first ? ~(tx_done & buffbypass_tx_done) : rec_first ? 0 : ~rx_ok; forced 1 while
//   gtwiz_reset_all_out=1. rec_first: 0->1 on rx_ok; 1->0 on tx_lost or reset_all.
//  rx_valid_out = rx_valid_in & lane_enable & {LANES{rx_ok}} (combinational, zero latency).
//  Counter widths: $clog2 of max(PULSE_CYCLES,TIMEOUT_CYCLES); retrain_count saturates at 15.
// STRUCTURE
//  Package ocx_dlx_xlx_pkg: FSM state enum (FIND_SYNC, HOLD_PULSE, PULSE_DONE, FAIL; 2 bits), width helper.
//  Sub-module ocx_dlx_debounce (sync + shift reg + hysteresis, param DEPTH); FSM/gating in top.
// TESTING
//  1 ocde held 1 for 8 cycles after reset -> reset_all_out 1->0 at cycle 8; 3-cycle low glitch -> no change.
//  2 LANES=8, lane_enable=8'h0F, run_lane=8'h0F -> rx_datapath_out high exactly 8 cycles; then rx_ok=1,
//    active=1 -> init_done=8'h0F.
//  3 rx_ok never rises, TIMEOUT_CYCLES=16 -> 3 retry pulses, retrain_count=3, then retrain_fail=1;
//    ocde low 5+ samples -> FIND_SYNC, fail clears.
//  4 in PULSE_DONE drop both tx_done -> FIND_SYNC next cycle, init_done=0, retrain_count unchanged.
//  5 send_first=0: dlx_reset=1 until rx_ok, stays 0 after rx_ok drops, re-asserts after tx_lost.
//  6 reset_n pulse mid HOLD_PULSE -> rx_datapath_out 0 immediately (async), all outputs at reset values.

Source files
------------

// File: rtl/ocx_dlx_xlx_pkg.sv
// Shared types and helpers for the DLx <-> GT glue: link FSM encoding and counter sizing.
package ocx_dlx_xlx_pkg;

  typedef enum logic [1:0] {
    StFindSync  = 2'd0,
    StHoldPulse = 2'd1,
    StPulseDone = 2'd2,
    StFail      = 2'd3
  } state_e;

  localparam logic [3:0] RetrainSat = 4'hF;

  function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ocx_dlx_xlx_if_gen_if.sv
// GT status, DLx lane signals and glue outputs bundled for the DLx <-> GT glue block.
interface ocx_dlx_xlx_if_gen_if #(
  parameter int unsigned LANES = 8
) ();
  logic             ocde;
  logic [LANES-1:0] lane_enable;
  logic             send_first;
  logic             gtwiz_reset_tx_done_in;
  logic             gtwiz_reset_rx_done_in;
  logic             gtwiz_buffbypass_tx_done_in;
  logic             gtwiz_buffbypass_rx_done_in;
  logic             gtwiz_userclk_rx_active_in;
  logic [LANES-1:0] pb_io_o0_rx_run_lane;
  logic [LANES-1:0] rx_valid_in;

  logic             gtwiz_reset_all_out;
  logic             gtwiz_reset_rx_datapath_out;
  logic             dlx_reset;
  logic [LANES-1:0] io_pb_o0_rx_init_done;
  logic [LANES-1:0] rx_valid_out;
  logic [3:0]       retrain_count;
  logic             retrain_fail;

  modport master (
    output ocde, lane_enable, send_first, gtwiz_reset_tx_done_in, gtwiz_reset_rx_done_in,
           gtwiz_buffbypass_tx_done_in, gtwiz_buffbypass_rx_done_in, gtwiz_userclk_rx_active_in,
           pb_io_o0_rx_run_lane, rx_valid_in,
    input  gtwiz_reset_all_out, gtwiz_reset_rx_datapath_out, dlx_reset, io_pb_o0_rx_init_done,
           rx_valid_out, retrain_count, retrain_fail
  );

  modport slave (
    input  ocde, lane_enable, send_first, gtwiz_reset_tx_done_in, gtwiz_reset_rx_done_in,
           gtwiz_buffbypass_tx_done_in, gtwiz_buffbypass_rx_done_in, gtwiz_userclk_rx_active_in,
           pb_io_o0_rx_run_lane, rx_valid_in,
    output gtwiz_reset_all_out, gtwiz_reset_rx_datapath_out, dlx_reset, io_pb_o0_rx_init_done,
           rx_valid_out, retrain_count, retrain_fail
  );
endinterface

// File: rtl/ocx_dlx_debounce.sv
// Two-flop synchroniser plus DEPTH-sample shift register with hysteresis; dout = 1 means reset.
module ocx_dlx_debounce #(
  parameter int unsigned DEPTH = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic             sync1_q, sync2_q;
  logic [DEPTH-1:0] shift_q, shift_d;
  logic             dout_q, dout_d;

  if (DEPTH > 1) begin : g_shift
    assign shift_d = {shift_q[DEPTH-2:0], sync2_q};
  end else begin : g_single
    assign shift_d = sync2_q;
  end

  // din low requests reset, so a full run of ones releases and a full run of zeros asserts.
  always_comb begin
    dout_d = dout_q;
    if (&shift_q && dout_q) begin
      dout_d = 1'b0;
    end else if (~|shift_q && !dout_q) begin
      dout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      shift_q <= '0;
      dout_q  <= 1'b1;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      shift_q <= shift_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/ocx_dlx_xlx_if_gen.sv
// DLx <-> Xilinx GT glue: reset-all debounce, rx datapath reset pulsing with watchdog retries,
// per-lane init_done / rx_valid gating and dlx_reset sequencing.
module ocx_dlx_xlx_if_gen
  import ocx_dlx_xlx_pkg::*;
#(
  parameter int unsigned LANES          = 8,
  parameter int unsigned PULSE_CYCLES   = 8,
  parameter int unsigned DEBOUNCE_DEPTH = 5,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned MAX_RETRAIN    = 3
) (
  input logic                 opt_gckn,
  input logic                 reset_n,
  ocx_dlx_xlx_if_gen_if.slave gt
);

  localparam int unsigned     CntW        = cnt_width(PULSE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] PulseLast   = CntW'(PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      MaxRetrain  = 4'(MAX_RETRAIN);

  logic reset_all;
  logic rx_ok, tx_lost, sync_all;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      retrain_q, retrain_d;
  logic            rec_first_q, rec_first_d;

  ocx_dlx_debounce #(
    .DEPTH (DEBOUNCE_DEPTH)
  ) u_debounce (
    .clk   (opt_gckn),
    .rst_n (reset_n),
    .din   (gt.ocde),
    .dout  (reset_all)
  );

  assign rx_ok    = gt.gtwiz_reset_rx_done_in & gt.gtwiz_buffbypass_rx_done_in;
  assign tx_lost  = ~gt.gtwiz_reset_tx_done_in & ~gt.gtwiz_buffbypass_tx_done_in;
  // An empty lane mask must never count as synced.
  assign sync_all = (|gt.lane_enable) & (&(gt.pb_io_o0_rx_run_lane | ~gt.lane_enable));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retrain_d = retrain_q;
    case (state_q)
      StFindSync: begin
        cnt_d = '0;
        if (sync_all) begin
          state_d   = StHoldPulse;
          retrain_d = '0;
        end
      end
      StHoldPulse: begin
        if (cnt_q == PulseLast) begin
          state_d = StPulseDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPulseDone: begin
        if (tx_lost) begin
          state_d = StFindSync;
          cnt_d   = '0;
        end else if (rx_ok) begin
          cnt_d = '0;
        end else if (cnt_q == TimeoutLast) begin
          cnt_d = '0;
          if (retrain_q == MaxRetrain) begin
            state_d = StFail;
          end else begin
            state_d = StHoldPulse;
            if (retrain_q != RetrainSat) retrain_d = retrain_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFail: begin
        cnt_d = '0;
      end
      default: begin
        state_d = StFindSync;
        cnt_d   = '0;
      end
    endcase
    if (reset_all) begin
      state_d = StFindSync;
      cnt_d   = '0;
    end
  end

  always_comb begin
    rec_first_d = rec_first_q ? ~(tx_lost | reset_all) : rx_ok;
  end

  always_ff @(posedge opt_gckn or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StFindSync;
      cnt_q       <= '0;
      retrain_q   <= '0;
      rec_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retrain_q   <= retrain_d;
      rec_first_q <= rec_first_d;
    end
  end

  always_comb begin
    gt.gtwiz_reset_all_out         = reset_all;
    gt.gtwiz_reset_rx_datapath_out = (state_q == StHoldPulse);
    gt.retrain_fail                = (state_q == StFail);
    gt.retrain_count               = retrain_q;
    gt.io_pb_o0_rx_init_done       = '0;
    if (state_q == StPulseDone) begin
      gt.io_pb_o0_rx_init_done = gt.lane_enable &
                                 {LANES{rx_ok & gt.gtwiz_userclk_rx_active_in}};
    end
    gt.rx_valid_out = gt.rx_valid_in & gt.lane_enable & {LANES{rx_ok}};
    if (reset_all) begin
      gt.dlx_reset = 1'b1;
    end else if (gt.send_first) begin
      gt.dlx_reset = ~(gt.gtwiz_reset_tx_done_in & gt.gtwiz_buffbypass_tx_done_in);
    end else if (rec_first_q) begin
      gt.dlx_reset = 1'b0;
    end else begin
      gt.dlx_reset = ~rx_ok;
    end
  end

endmodule

// File: tb/tb_ocx_dlx_xlx_if_gen.sv
// Self-checking bench for ocx_dlx_xlx_if_gen: directed link sequences, a gating vector table
// and randomized gating / dlx_reset checks against a small reference model.
module tb_ocx_dlx_xlx_if_gen;

  localparam int unsigned Lanes = 8;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ocx_dlx_xlx_if_gen_if #(.LANES(Lanes)) bus ();

  ocx_dlx_xlx_if_gen #(
    .LANES          (Lanes),
    .PULSE_CYCLES   (8),
    .DEBOUNCE_DEPTH (5),
    .TIMEOUT_CYCLES (16),
    .MAX_RETRAIN    (3)
  ) dut (
    .opt_gckn (clk),
    .reset_n  (reset_n),
    .gt       (bus)
  );

  typedef struct {
    logic [7:0] lane_enable;
    logic [7:0] rx_valid_in;
    logic       rx_done;
    logic       bb_rx_done;
    logic [7:0] exp_rx_valid;
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_tx(input logic t, input logic b);
    bus.gtwiz_reset_tx_done_in      = t;
    bus.gtwiz_buffbypass_tx_done_in = b;
  endtask

  task automatic set_rx(input logic r, input logic b);
    bus.gtwiz_reset_rx_done_in      = r;
    bus.gtwiz_buffbypass_rx_done_in = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k, hi_cnt, first_hi, pulses;
    logic prev_dp, rec, rx_ok, tx_lost, exp_dlx;
    logic [7:0] exp_valid, allowed;

    vecs[0] = '{8'hFF, 8'hA5, 1'b1, 1'b1, 8'hA5};
    vecs[1] = '{8'h0F, 8'hFF, 1'b1, 1'b1, 8'h0F};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 8'h00};
    vecs[4] = '{8'h00, 8'hFF, 1'b1, 1'b1, 8'h00};
    vecs[5] = '{8'hF0, 8'h3C, 1'b1, 1'b1, 8'h30};

    reset_n = 1'b0;
    bus.ocde = 1'b0;
    bus.lane_enable = '0;
    bus.send_first = 1'b0;
    set_tx(1'b0, 1'b0);
    set_rx(1'b0, 1'b0);
    bus.gtwiz_userclk_rx_active_in = 1'b0;
    bus.pb_io_o0_rx_run_lane = '0;
    bus.rx_valid_in = '0;
    tick(2);

    chk("reset reset_all", 32'(bus.gtwiz_reset_all_out), 32'd1);
    chk("reset dlx_reset", 32'(bus.dlx_reset), 32'd1);
    chk("reset rx_datapath", 32'(bus.gtwiz_reset_rx_datapath_out), 32'd0);
    chk("reset init_done", 32'(bus.io_pb_o0_rx_init_done), 32'd0);
    chk("reset retrain_count", 32'(bus.retrain_count), 32'd0);
    chk("reset retrain_fail", 32'(bus.retrain_fail), 32'd0);

    // Debounce release latency and glitch rejection.
    reset_n = 1'b1;
    bus.ocde = 1'b1;
    tick(7);
    chk("debounce still held @7", 32'(bus.gtwiz_reset_all_out), 32'd1);
    tick(1);
    chk("debounce release @8", 32'(bus.gtwiz_reset_all_out), 32'd0);
    bus.ocde = 1'b0;
    tick(3);
    bus.ocde = 1'b1;
    tick(10);
    chk("glitch ignored", 32'(bus.gtwiz_reset_all_out), 32'd0);

    // Empty lane mask never syncs.
    bus.pb_io_o0_rx_run_lane = 8'hFF;
    tick(3);
    chk("no sync with mask 0", 32'(bus.gtwiz_reset_rx_datapath_out), 32'd0);

    // Masked sync and pulse width.
    set_tx(1'b1, 1'b1);
    bus.gtwiz_userclk_rx_active_in = 1'b1;
    bus.lane_enable = 8'h0F;
    bus.pb_io_o0_rx_run_lane = 8'h0F;
    hi_cnt = 0;
    first_hi = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (bus.gtwiz_reset_rx_datapath_out) begin
        hi_cnt++;
        if (first_hi == 0) first_hi = i;
      end
    end
    chk("pulse width", 32'(hi_cnt), 32'd8);
    chk("pulse start", 32'(first_hi), 32'd1);
    chk("init_done before rx_ok", 32'(bus.io_pb_o0_rx_init_done), 32'd0);
    set_rx(1'b1, 1'b1);
    #1;
    chk("init_done masked", 32'(bus.io_pb_o0_rx_init_done), 32'h0F);
    tick(1);

    // Watchdog retry: rx_ok drops, expect a new pulse after 16 idle cycles.
    set_rx(1'b0, 1'b0);
    k = 0;
    while (k < 40 && !bus.gtwiz_reset_rx_datapath_out) begin
      tick(1);
      k++;
    end
    chk("timeout cycles", 32'(k), 32'd16);
    chk("retrain_count after retry", 32'(bus.retrain_count), 32'd1);
    tick(8);
    set_rx(1'b1, 1'b1);
    #1;
    chk("init_done after retry", 32'(bus.io_pb_o0_rx_init_done), 32'h0F);

    // tx lost in PULSE_DONE drops back to FIND_SYNC without counting.
    set_tx(1'b0, 1'b0);
    tick(1);
    chk("tx_lost init_done", 32'(bus.io_pb_o0_rx_init_done), 32'd0);
    chk("tx_lost no pulse", 32'(bus.gtwiz_reset_rx_datapath_out), 32'd0);
    chk("tx_lost count kept", 32'(bus.retrain_count), 32'd1);

    // Fresh sync with rx_ok never rising: 1 pulse + 3 retries, then FAIL.
    set_tx(1'b1, 1'b1);
    set_rx(1'b0, 1'b0);
    pulses = 0;
    prev_dp = 1'b0;
    k = 0;
    while (k < 150 && !bus.retrain_fail) begin
      tick(1);
      k++;
      if (bus.gtwiz_reset_rx_datapath_out && !prev_dp) pulses++;
      prev_dp = bus.gtwiz_reset_rx_datapath_out;
    end
    chk("cycles to fail", 32'(k), 32'd97);
    chk("pulses to fail", 32'(pulses), 32'd4);
    chk("fail retrain_count", 32'(bus.retrain_count), 32'd3);
    set_rx(1'b1, 1'b1);
    #1;
    chk("fail init_done", 32'(bus.io_pb_o0_rx_init_done), 32'd0);
    bus.ocde = 1'b0;
    tick(8);
    chk("ocde low reset_all", 32'(bus.gtwiz_reset_all_out), 32'd1);
    chk("fail held before exit", 32'(bus.retrain_fail), 32'd1);
    tick(1);
    chk("fail cleared", 32'(bus.retrain_fail), 32'd0);
    tick(2);
    chk("reset_all blocks sync", 32'(bus.gtwiz_reset_rx_datapath_out), 32'd0);

    // Async reset in the middle of a pulse.
    set_rx(1'b0, 1'b0);
    bus.ocde = 1'b1;
    tick(9);
    chk("pulse restarted", 32'(bus.gtwiz_reset_rx_datapath_out), 32'd1);
    tick(3);
    reset_n = 1'b0;
    #1;
    chk("async rx_datapath", 32'(bus.gtwiz_reset_rx_datapath_out), 32'd0);
    chk("async reset_all", 32'(bus.gtwiz_reset_all_out), 32'd1);
    chk("async dlx_reset", 32'(bus.dlx_reset), 32'd1);
    chk("async retrain_count", 32'(bus.retrain_count), 32'd0);
    chk("async retrain_fail", 32'(bus.retrain_fail), 32'd0);
    tick(1);

    // Receive-first dlx_reset sequencing.
    reset_n = 1'b1;
    bus.lane_enable = '0;
    tick(8);
    chk("rf reset_all released", 32'(bus.gtwiz_reset_all_out), 32'd0);
    chk("rf dlx held", 32'(bus.dlx_reset), 32'd1);
    set_rx(1'b1, 1'b1);
    #1;
    chk("rf dlx on rx_ok", 32'(bus.dlx_reset), 32'd0);
    tick(1);
    set_rx(1'b0, 1'b0);
    #1;
    chk("rf dlx stays low", 32'(bus.dlx_reset), 32'd0);
    tick(2);
    chk("rf dlx still low", 32'(bus.dlx_reset), 32'd0);
    set_tx(1'b0, 1'b0);
    #1;
    chk("rf dlx before tx_lost edge", 32'(bus.dlx_reset), 32'd0);
    tick(1);
    chk("rf dlx after tx_lost", 32'(bus.dlx_reset), 32'd1);
    bus.send_first = 1'b1;
    set_tx(1'b1, 1'b0);
    #1;
    chk("sf one tx done", 32'(bus.dlx_reset), 32'd1);
    set_tx(1'b1, 1'b1);
    #1;
    chk("sf tx ready", 32'(bus.dlx_reset), 32'd0);

    // Gating table.
    foreach (vecs[i]) begin
      bus.lane_enable = vecs[i].lane_enable;
      bus.rx_valid_in = vecs[i].rx_valid_in;
      set_rx(vecs[i].rx_done, vecs[i].bb_rx_done);
      #1;
      chk($sformatf("vec%0d rx_valid_out", i), 32'(bus.rx_valid_out), 32'(vecs[i].exp_rx_valid));
      tick(1);
    end

    // Force rec_first low so the model starts from a known value.
    set_rx(1'b0, 1'b0);
    set_tx(1'b0, 1'b0);
    tick(1);
    rec = 1'b0;

    for (int i = 0; i < 200; i++) begin
      bus.lane_enable = 8'($urandom);
      bus.rx_valid_in = 8'($urandom);
      bus.pb_io_o0_rx_run_lane = 8'($urandom);
      bus.send_first = 1'($urandom_range(1));
      bus.gtwiz_userclk_rx_active_in = ($urandom_range(3) != 0);
      set_rx(($urandom_range(3) != 0), ($urandom_range(3) != 0));
      set_tx(($urandom_range(3) != 0), ($urandom_range(3) != 0));
      #1;
      rx_ok = bus.gtwiz_reset_rx_done_in && bus.gtwiz_buffbypass_rx_done_in;
      tx_lost = !bus.gtwiz_reset_tx_done_in && !bus.gtwiz_buffbypass_tx_done_in;
      exp_valid = rx_ok ? (bus.rx_valid_in & bus.lane_enable) : 8'h00;
      if (bus.send_first)
        exp_dlx = !(bus.gtwiz_reset_tx_done_in && bus.gtwiz_buffbypass_tx_done_in);
      else
        exp_dlx = rec ? 1'b0 : !rx_ok;
      allowed = (rx_ok && bus.gtwiz_userclk_rx_active_in) ? bus.lane_enable : 8'h00;
      chk("rand rx_valid_out", 32'(bus.rx_valid_out), 32'(exp_valid));
      chk("rand dlx_reset", 32'(bus.dlx_reset), 32'(exp_dlx));
      chk("rand init_done within gate", 32'(bus.io_pb_o0_rx_init_done & ~allowed), 32'd0);
      // Receive-first memory: set by rx_ok, cleared by loss of both tx dones.
      if (rec) rec = !tx_lost;
      else     rec = rx_ok;
      tick(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
